// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the data memory arbiter slice.
package data_mem_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int MEM_AW_DEF = 8;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LOAD  = 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; last_grant only advances when enabled and a grant is issued.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       req0,
    input  logic       req1,
    output logic [1:0] grant
);
    logic last_grant;

    // On contention the port that did not win last time takes the grant.
    always_comb begin
        grant = {req1, req0};
        if (req0 && req1)
            grant = last_grant ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= 1'b1;
        else if (en && |grant)
            last_grant <= grant[1];
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin front end for the registered-read data_memory.
// Each access takes IDLE -> ISSUE -> RESP; all outputs are registered.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int MEM_AW = MEM_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rerr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rerr1,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_read_data
);
    state_t            state, state_nxt;
    logic [1:0]        grant;
    logic              win_id;
    logic              oor;
    logic              arb_win;
    logic [ADDR_W-1:0] addr_sel;
    logic              oor_sel;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (state == IDLE),
        .req0  (req0),
        .req1  (req1),
        .grant (grant)
    );

    assign arb_win  = (state == IDLE) && |grant;
    assign addr_sel = grant[1] ? addr1 : addr0;
    assign oor_sel  = |addr_sel[ADDR_W-1:MEM_AW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are computed one state early so every output comes straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_id      <= PORT_FETCH;
            oor         <= 1'b0;
            mem_address <= '0;
            mem_read    <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            rerr0       <= 1'b0;
            rerr1       <= 1'b0;
        end else begin
            gnt0     <= arb_win && grant[0];
            gnt1     <= arb_win && grant[1];
            mem_read <= arb_win && !oor_sel;
            rvalid0  <= (state == RESP) && (win_id == PORT_FETCH);
            rvalid1  <= (state == RESP) && (win_id == PORT_LOAD);
            if (arb_win) begin
                win_id      <= grant[1];
                mem_address <= addr_sel;
                oor         <= oor_sel;
            end
            if (state == RESP) begin
                if (win_id == PORT_FETCH) begin
                    rdata0 <= oor ? '0 : mem_read_data;
                    rerr0  <= oor;
                end else begin
                    rdata1 <= oor ? '0 : mem_read_data;
                    rerr1  <= oor;
                end
            end
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter against a transaction-scheduling reference model.
module tb_data_mem_arbiter;
    localparam int NC = 2400;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic        gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1;
    logic [31:0] rdata0, rdata1;
    logic        mem_read;
    logic [31:0] mem_address;
    logic [31:0] mem_read_data;

    logic [31:0] mem [256];

    data_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .rerr0(rerr0),
        .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .rerr1(rerr1),
        .mem_read(mem_read), .mem_address(mem_address), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Registered-read memory behaviour.
    always @(posedge clk) if (mem_read) mem_read_data <= mem[mem_address[7:0]];

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at time %0t", tag, got, exp, $time);
        end
    endtask

    // Expected events scheduled per cycle when a transaction is awarded.
    bit [1:0]    e_gnt  [NC];
    bit          e_rd   [NC];
    bit          e_aset [NC];
    logic [31:0] e_addr [NC];
    bit [1:0]    e_rv   [NC];
    logic [31:0] e_data [NC];
    bit          e_err  [NC];
    logic [31:0] exp_rdata [2];
    bit          exp_rerr  [2];
    logic [31:0] exp_maddr;
    int          free_at;
    int          last;
    int          cyc;
    bit [1:0]    granted;

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            e_gnt[i] = '0; e_rd[i] = 0; e_aset[i] = 0; e_addr[i] = '0;
            e_rv[i] = '0; e_data[i] = '0; e_err[i] = 0;
        end
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        exp_rerr[0] = 0;   exp_rerr[1] = 0;
        exp_maddr = '0;
        free_at = cyc;
        last = 1;
        granted = '0;
    endtask

    task automatic chk_all_zero();
        chk("rst_gnt",   {30'd0, gnt1, gnt0}, 32'd0);
        chk("rst_rv",    {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("rst_rerr",  {30'd0, rerr1, rerr0}, 32'd0);
        chk("rst_rd0",   rdata0, 32'd0);
        chk("rst_rd1",   rdata1, 32'd0);
        chk("rst_mread", {31'd0, mem_read}, 32'd0);
        chk("rst_maddr", mem_address, 32'd0);
    endtask

    // One cycle: check outputs of cycle cyc, arbitrate on its inputs, advance to next cycle.
    task automatic step();
        int w;
        logic [31:0] a;
        bit oor;
        @(negedge clk);
        if (e_aset[cyc]) exp_maddr = e_addr[cyc];
        for (int p = 0; p < 2; p++)
            if (e_rv[cyc][p]) begin
                exp_rdata[p] = e_data[cyc];
                exp_rerr[p]  = e_err[cyc];
            end
        chk("gnt0",    {31'd0, gnt0},    {31'd0, e_gnt[cyc][0]});
        chk("gnt1",    {31'd0, gnt1},    {31'd0, e_gnt[cyc][1]});
        chk("mem_read",{31'd0, mem_read},{31'd0, e_rd[cyc]});
        chk("mem_addr", mem_address, exp_maddr);
        chk("rvalid0", {31'd0, rvalid0}, {31'd0, e_rv[cyc][0]});
        chk("rvalid1", {31'd0, rvalid1}, {31'd0, e_rv[cyc][1]});
        chk("rdata0",  rdata0, exp_rdata[0]);
        chk("rdata1",  rdata1, exp_rdata[1]);
        chk("rerr",    {30'd0, rerr1, rerr0}, {30'd0, exp_rerr[1], exp_rerr[0]});
        granted = '0;
        if (cyc >= free_at && (req0 || req1)) begin
            w   = (req0 && req1) ? (last == 0 ? 1 : 0) : (req1 ? 1 : 0);
            a   = w ? addr1 : addr0;
            oor = (a >> 8) != 0;
            e_gnt[cyc+1][w] = 1;
            e_rd[cyc+1]     = !oor;
            e_aset[cyc+1]   = 1;
            e_addr[cyc+1]   = a;
            e_rv[cyc+3][w]  = 1;
            e_data[cyc+3]   = oor ? 32'd0 : mem[a[7:0]];
            e_err[cyc+3]    = oor;
            free_at = cyc + 3;
            last    = w;
            granted[w] = 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return $urandom() | 32'h100;
        return 32'($urandom_range(0, 255));
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        mem[8'h10] = 32'hDEADBEEF;
        mem[1] = 32'h11;
        mem[2] = 32'h22;
        req0 = 0; req1 = 0; addr0 = '0; addr1 = '0;
        reset = 1;
        cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero();
        reset = 0;
        model_reset();

        // Single fetch, dropped after the grant.
        req0 = 1; addr0 = 32'h10;
        step();
        req0 = 0;
        idle_steps(5);

        // Both ports contending continuously.
        req0 = 1; addr0 = 32'h1; req1 = 1; addr1 = 32'h2;
        idle_steps(13);
        req0 = 0; req1 = 0;
        idle_steps(3);

        // Port 1 alone, held.
        req1 = 1; addr1 = 32'h2;
        idle_steps(10);
        req1 = 0;
        idle_steps(3);

        // Out-of-range fetch.
        req0 = 1; addr0 = 32'h400;
        step();
        req0 = 0;
        idle_steps(4);

        // Reset during ISSUE of a port 1 access.
        req1 = 1; addr1 = 32'h7;
        step();
        req1 = 0;
        #1 reset = 1;
        #1 chk_all_zero();
        @(posedge clk);
        #1 reset = 0;
        cyc++;
        model_reset();
        idle_steps(3);
        req0 = 1; addr0 = 32'h3; req1 = 1; addr1 = 32'h4;
        idle_steps(7);
        req0 = 0; req1 = 0;
        idle_steps(3);

        // Random traffic obeying the hold-until-grant protocol.
        for (int i = 0; i < 1800; i++) begin
            if (granted[0]) begin
                if ($urandom_range(0, 1) == 0) req0 = 0; else addr0 = rand_addr();
            end else if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1; addr0 = rand_addr();
            end
            if (granted[1]) begin
                if ($urandom_range(0, 1) == 0) req1 = 0; else addr1 = rand_addr();
            end else if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1; addr1 = rand_addr();
            end
            step();
        end
        req0 = 0; req1 = 0;
        idle_steps(4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
